// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with bounded grant hold time.
// Optional build macro MUX_ARB_LOCK_EN adds lock_i, which suppresses timeout rotation.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef MUX_ARB_LOCK_EN
  input  logic              lock_i,
`endif
  input  logic [3:0]        req_i,
  output logic [3:0]        gnt_o,
  output logic [1:0]        sel_o,
  output logic              valid_o,
  output logic [HOLD_W-1:0] hold_cnt_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [3:0]        gnt_q;
  logic [1:0]        sel_q;
  logic              valid_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [1:0]        last_q;

  logic              lock;
  logic [3:0]        cand;
  logic              pick_any;
  logic [1:0]        pick_idx;
  logic              owner_req;
  logic              hold_max;

`ifdef MUX_ARB_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  // The owner is never a candidate: it is either dropping or being rotated out on timeout.
  assign cand      = req_i & ~gnt_q;
  assign owner_req = |(req_i & gnt_q);
  assign hold_max  = (hold_cnt_q == HOLD_W'(MAX_HOLD));

  always_comb begin
    logic [1:0] idx;
    pick_any = 1'b0;
    pick_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!pick_any && cand[idx]) begin
        pick_any = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= 2'd3;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            state_q    <= StBusy;
            gnt_q      <= 4'b0001 << pick_idx;
            sel_q      <= pick_idx;
            valid_q    <= 1'b1;
            hold_cnt_q <= HOLD_W'(1);
            last_q     <= pick_idx;
          end
        end
        StBusy: begin
          if (!owner_req || (hold_max && !lock)) begin
            if (pick_any) begin
              gnt_q      <= 4'b0001 << pick_idx;
              sel_q      <= pick_idx;
              hold_cnt_q <= HOLD_W'(1);
              last_q     <= pick_idx;
            end else if (!owner_req) begin
              state_q    <= StIdle;
              gnt_q      <= 4'b0000;
              valid_q    <= 1'b0;
              hold_cnt_q <= '0;
            end
            // Timed out with nobody waiting: owner keeps the grant, count stays saturated.
          end else if (!hold_max) begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign sel_o      = sel_q;
  assign valid_o    = valid_q;
  assign hold_cnt_o = hold_cnt_q;

endmodule
